// File: rtl/mux4_scan_ctrl.sv
// Round-robin scan controller for a 4-to-1 selector: drives {e0,e1}, dwells, captures f per channel.
// Optional frame parity output is enabled by defining MUX4_SCAN_PARITY_EN.
module mux4_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       cont,
    input  logic [3:0] mask,
    input  logic       f,
    output logic       e0,
    output logic       e1,
    output logic       busy,
    output logic [3:0] sample,
    output logic       sample_valid,
    output logic [1:0] sample_ch,
    output logic       frame_done
`ifdef MUX4_SCAN_PARITY_EN
    ,
    output logic       frame_parity
`endif
);

    typedef enum logic {ST_IDLE, ST_DWELL} state_t;

    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  sample_q, sample_d;
    logic        valid_q, valid_d;
    logic [1:0]  ch_q, ch_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic [3:0]  above;
`ifdef MUX4_SCAN_PARITY_EN
    logic        parity_q, parity_d;
`endif

    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        lowest_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) lowest_ch = 2'(i);
        end
    endfunction

    // Enabled channels strictly above the current one; empty means frame end.
    assign above = mask_q & (4'b1110 << idx_q);

    always_comb begin
        // NOTE: every _d defaults to its hold value first, so no path can infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        ch_d     = ch_q;
        done_d   = 1'b0;
`ifdef MUX4_SCAN_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q == ST_IDLE) begin
            if (start && !stop && mask != 4'd0) begin
                state_d = ST_DWELL;
                mask_d  = mask;
                idx_d   = lowest_ch(mask);
                cnt_d   = CNT_LOAD;
            end
        end else begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                sample_d[idx_q] = f;
                valid_d         = 1'b1;
                ch_d            = idx_q;
                if (above != 4'd0) begin
                    idx_d = lowest_ch(above);
                    cnt_d = CNT_LOAD;
                end else begin
                    done_d = !stop;
`ifdef MUX4_SCAN_PARITY_EN
                    if (!stop) parity_d = ^(sample_d & mask_q);
`endif
                    if (cont && mask != 4'd0) begin
                        mask_d = mask;
                        idx_d  = lowest_ch(mask);
                        cnt_d  = CNT_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            // Abort wins over any advance, but a coinciding capture above still lands.
            if (stop) begin
                state_d = ST_IDLE;
                idx_d   = idx_q;
            end
        end
        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= '0;
            mask_q   <= 4'd0;
            sample_q <= 4'd0;
            valid_q  <= 1'b0;
            ch_q     <= 2'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MUX4_SCAN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            ch_q     <= ch_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef MUX4_SCAN_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign e0           = idx_q[1];
    assign e1           = idx_q[0];
    assign busy         = busy_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign sample_ch    = ch_q;
    assign frame_done   = done_q;
`ifdef MUX4_SCAN_PARITY_EN
    assign frame_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Self-checking bench for mux4_scan_ctrl: directed sequences, randomized run against a
// queue-based frame model, and a DWELL=1 vector table on a second instance.
module tb_mux4_scan_ctrl;

    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, cont, f;
    logic [3:0] mask;
    logic       e0, e1, busy, sample_valid, frame_done;
    logic [3:0] sample;
    logic [1:0] sample_ch;

    logic       start1, stop1, cont1, f1;
    logic [3:0] mask1;
    logic       e0_1, e1_1, busy1, sample_valid1, frame_done1;
    logic [3:0] sample1;
    logic [1:0] sample_ch1;
`ifdef MUX4_SCAN_PARITY_EN
    logic       frame_parity, frame_parity1;
`endif

    always #5 clk = ~clk;

    mux4_scan_ctrl #(.DWELL(DWELL), .CW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont), .mask(mask), .f(f),
        .e0(e0), .e1(e1), .busy(busy), .sample(sample), .sample_valid(sample_valid),
        .sample_ch(sample_ch), .frame_done(frame_done)
`ifdef MUX4_SCAN_PARITY_EN
        , .frame_parity(frame_parity)
`endif
    );

    mux4_scan_ctrl #(.DWELL(1), .CW(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop1), .cont(cont1), .mask(mask1), .f(f1),
        .e0(e0_1), .e1(e1_1), .busy(busy1), .sample(sample1), .sample_valid(sample_valid1),
        .sample_ch(sample_ch1), .frame_done(frame_done1)
`ifdef MUX4_SCAN_PARITY_EN
        , .frame_parity(frame_parity1)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is the queue of enabled channels; each capture is scheduled
    // DWELL edges after its select is presented.
    int unsigned cyc = 0;
    int unsigned m_cap;
    bit          m_active;
    int          m_pend[$];
    logic [1:0]  m_sel, m_ch;
    logic [3:0]  m_sample, m_fmask;
    logic        m_valid, m_done, m_par;

    logic [3:0]  pat;
    bit          pat_on = 1'b0;

    task automatic model_reset();
        m_active = 1'b0; m_pend = {}; m_sel = 2'd0; m_ch = 2'd0;
        m_sample = 4'd0; m_fmask = 4'd0; m_valid = 1'b0; m_done = 1'b0; m_par = 1'b0;
    endtask

    task automatic load_frame(input logic [3:0] m);
        m_pend = {};
        for (int i = 0; i < 4; i++) if (m[i]) m_pend.push_back(i);
        m_fmask = m;
        m_sel   = 2'(m_pend[0]);
        m_cap   = cyc + DWELL;
    endtask

    task automatic model_step();
        int ch;
        m_valid = 1'b0;
        m_done  = 1'b0;
        if (m_active) begin
            if (cyc == m_cap) begin
                ch = m_pend.pop_front();
                m_sample[ch] = f;
                m_valid = 1'b1;
                m_ch = 2'(ch);
                if (m_pend.size() == 0) begin
                    if (!stop) begin
                        m_done = 1'b1;
                        m_par  = ^(m_sample & m_fmask);
                    end
                    if (!stop && cont && mask != 4'd0) load_frame(mask);
                    else m_active = 1'b0;
                end else if (stop) begin
                    m_active = 1'b0;
                end else begin
                    m_sel = 2'(m_pend[0]);
                    m_cap = cyc + DWELL;
                end
            end else if (stop) begin
                m_active = 1'b0;
            end
        end else if (start && !stop && mask != 4'd0) begin
            m_active = 1'b1;
            load_frame(mask);
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("busy", busy, m_active);
        check("sel", {e0, e1}, m_sel);
        check("valid", sample_valid, m_valid);
        check("ch", sample_ch, m_ch);
        check("done", frame_done, m_done);
        check("sample", sample, m_sample);
`ifdef MUX4_SCAN_PARITY_EN
        check("parity", frame_parity, m_par);
`endif
        if (pat_on) f = pat[m_sel];
    endtask

    typedef struct {
        logic       start;
        logic [3:0] mask;
        logic       f;
        logic       busy;
        logic [1:0] sel;
        logic       valid;
        logic [1:0] ch;
        logic       done;
        logic [3:0] sample;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b1, 4'hF, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[1] = '{1'b0, 4'hF, 1'b1, 1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 4'b0001};
        tbl[2] = '{1'b0, 4'hF, 1'b0, 1'b1, 2'd2, 1'b1, 2'd1, 1'b0, 4'b0001};
        tbl[3] = '{1'b0, 4'hF, 1'b1, 1'b1, 2'd3, 1'b1, 2'd2, 1'b0, 4'b0101};
        tbl[4] = '{1'b0, 4'hF, 1'b1, 1'b0, 2'd3, 1'b1, 2'd3, 1'b1, 4'b1101};
        tbl[5] = '{1'b0, 4'hF, 1'b0, 1'b0, 2'd3, 1'b0, 2'd3, 1'b0, 4'b1101};

        rst = 1'b1; start = 0; stop = 0; cont = 0; mask = 0; f = 0;
        start1 = 0; stop1 = 0; cont1 = 0; mask1 = 0; f1 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_outs", {e0, e1, busy, sample, sample_valid, sample_ch, frame_done}, 0);
        rst = 1'b0;

        // Full scan, f follows the select: A=1 B=0 C=1 D=1.
        pat = 4'b1101; pat_on = 1'b1; f = pat[0];
        mask = 4'hF; cont = 0; start = 1;
        tick();
        start = 0;
        check("fs_sel_first", {e0, e1}, 2'd0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("fs_sel", {e0, e1}, (k < 16) ? k / 4 : 3);
            check("fs_valid", sample_valid, (k % 4) == 0);
            if (k % 4 == 0) check("fs_ch", sample_ch, k / 4 - 1);
            check("fs_done", frame_done, k == 16);
        end
        check("fs_busy_end", busy, 0);
        check("fs_sample", sample, 4'b1101);
`ifdef MUX4_SCAN_PARITY_EN
        check("fs_parity", frame_parity, 1);
`endif
        pat_on = 1'b0;

        // Asynchronous reset mid-dwell, observed before the next rising edge.
        mask = 4'hF; start = 1; tick(); start = 0; tick();
        #2 rst = 1'b1;
        #1 check("rst_async", {e0, e1, busy, sample, sample_valid, sample_ch, frame_done}, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Sparse mask: only channels 1 and 3.
        f = 1; mask = 4'b1010; start = 1; tick(); start = 0;
        check("sp_sel_first", {e0, e1}, 2'd1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 4) check("sp_ch1", {sample_valid, sample_ch}, {1'b1, 2'd1});
            if (k == 8) check("sp_done_ch3", {frame_done, sample_ch}, {1'b1, 2'd3});
        end
        check("sp_sample", sample, 4'b1010);

        // Stop in the second dwell cycle of channel 1.
        f = 0; mask = 4'hF; start = 1; tick(); start = 0;
        repeat (5) tick();
        stop = 1; tick(); stop = 0;
        check("stop_busy", busy, 0);
        check("stop_sel", {e0, e1}, 2'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("stop_no_done", frame_done, 0);
        end
        check("stop_bit1", sample[1], 1);

        // Continuous mode with a mid-frame mask change.
        f = 1; cont = 1; mask = 4'b0001; start = 1; tick(); start = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) mask = 4'b0100;
            if (k == 9) cont = 0;
            tick();
            if (k == 4) check("ct_first", {frame_done, sample_ch, e0, e1}, {1'b1, 2'd0, 2'd2});
            if (k == 8) check("ct_second", {frame_done, sample_ch, busy}, {1'b1, 2'd2, 1'b1});
            if (k == 12) check("ct_last", {frame_done, busy}, {1'b1, 1'b0});
        end

        // Start with an empty mask is ignored.
        mask = 4'd0; start = 1; tick(); start = 0;
        check("mask0_busy", busy, 0);

        // Randomized run against the model.
        for (int k = 0; k < 2000; k++) begin
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 31) == 0) cont = $urandom_range(0, 1);
            mask  = 4'($urandom_range(0, 15));
            f     = $urandom_range(0, 1);
            tick();
        end
        start = 0; stop = 0; cont = 0;

        // DWELL=1 instance, table-driven.
        for (int r = 0; r < 6; r++) begin
            start1 = tbl[r].start; mask1 = tbl[r].mask; f1 = tbl[r].f;
            @(posedge clk);
            @(negedge clk);
            check("d1_busy", busy1, tbl[r].busy);
            check("d1_sel", {e0_1, e1_1}, tbl[r].sel);
            check("d1_valid", sample_valid1, tbl[r].valid);
            check("d1_ch", sample_ch1, tbl[r].ch);
            check("d1_done", frame_done1, tbl[r].done);
            check("d1_sample", sample1, tbl[r].sample);
        end
`ifdef MUX4_SCAN_PARITY_EN
        check("d1_parity", frame_parity1, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4_scan_ctrl.md
Name: mux4_scan_ctrl

Overview:
- Scan controller for the 4-to-1 bit selector stage: drives its select pair (e0, e1) and samples its output f back into a 4-bit result register.
- Steps round-robin through the enabled channels and holds each select for a programmable dwell, so the selector output settles before capture.
- Channel index idx = {e0, e1}: A=0, B=1, C=2, D=3.

Parameters:
- DWELL, 4, cycles each select is held before f is captured; legal range 1..255.
- CW, 8, dwell counter width; must hold DWELL-1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- start  input  1  one-cycle request to begin a scan; ignored unless idle
- stop  input  1  abort the scan; priority over start
- cont  input  1  1 = continuous scanning, 0 = single frame
- mask  input  4  channel enable, bit i = channel i; sampled at start and at each frame boundary
- f  input  1  selector output being sampled
- e0  output  1  select MSB to the selector
- e1  output  1  select LSB to the selector
- busy  output  1  high while not IDLE
- sample  output  4  last captured f per channel; bit i = channel i
- sample_valid  output  1  one-cycle pulse, cycle after a capture
- sample_ch  output  2  channel of the capture flagged by sample_valid
- frame_done  output  1  one-cycle pulse, same cycle as the sample_valid of the last enabled channel

Behaviour:
- Reset values (asynchronous): state=IDLE, e0=e1=0, busy=0, sample=4'b0, sample_valid=0, sample_ch=0, frame_done=0, dwell counter=0, mask_q=0. Reset mid-scan aborts immediately.
- All outputs are registered.
- States: IDLE, DWELL.
- IDLE -> DWELL:
  - Trigger: start=1, stop=0 and mask!=0.
  - Load mask_q=mask.
  - Set idx to the lowest enabled channel; drive {e0, e1}=idx.
  - Load cnt=DWELL-1.
  - start with mask=0: no action, stay IDLE.
- DWELL, cnt>0: cnt decrements; selects held.
- DWELL, cnt==0 (capture cycle):
  - sample[idx] <= f; all other sample bits unchanged.
  - Next cycle: sample_valid=1, sample_ch=captured idx.
  - If idx is not the highest set bit of mask_q: idx <= next higher enabled channel, cnt <= DWELL-1, stay DWELL.
  - If idx is the highest set bit (frame end): frame_done pulses with the following sample_valid.
    - cont=1 and mask!=0: reload mask_q=mask, idx = lowest enabled channel, cnt=DWELL-1, stay DWELL.
    - cont=0, or mask==0 at the boundary: go IDLE.
- Capture latency: f is sampled DWELL cycles after the select change. With DWELL=1, a new select appears every cycle.
- stop=1 in DWELL:
  - Next cycle: IDLE, busy=0.
  - A capture coinciding with stop still completes, and its sample_valid still pulses.
  - No frame_done is issued for an aborted frame.
  - e0/e1 hold their last value.
- start while busy: ignored.
- mask changes mid-frame: no effect until the next frame boundary.
- Single-channel mask: every capture is a frame end, so frame_done pulses with every sample_valid.
- In IDLE, e0/e1 keep the last driven value and sample keeps its contents.

Optional Feature:
- Macro: MUX4_SCAN_PARITY_EN.
- Defined:
  - Adds output frame_parity (1 bit, reset 0).
  - Updated on the cycle frame_done pulses, with the XOR of sample bits whose mask_q bit is set (using the just-completed capture).
  - Holds its value otherwise; not updated on an aborted frame.
- Not defined: port absent, no parity logic.

Test Plan:
- Full scan: DWELL=4, mask=4'b1111, cont=0, f driven as A=1, B=0, C=1, D=1 (f follows {e0, e1}), start pulse.
  -> e0e1 sequence 00, 01, 10, 11, each held 4 cycles.
  -> sample=4'b1101 (D,C,B,A = bits 3..0).
  -> 4 sample_valid pulses with sample_ch 0, 1, 2, 3; frame_done with the 4th.
  -> busy low after the 16 dwell cycles; parity=1 if MUX4_SCAN_PARITY_EN is defined.
- Sparse mask: mask=4'b1010, f=1.
  -> only channels 1 and 3 are visited; sample bits 0 and 2 stay 0; frame_done on sample_ch=3.
- Continuous mode and mask boundary: cont=1, mask=4'b0001, then mask changed to 4'b0100 mid-frame.
  -> channel 0 is kept until the frame ends; then channel 2 is scanned; frame_done pulses every DWELL cycles.
- Stop: stop asserted in cycle 2 of channel 1's dwell.
  -> IDLE next cycle, no frame_done, sample bit 1 unchanged, e0e1 holds 01.
- Reset and ignored start: rst pulsed mid-dwell -> all outputs 0 asynchronously, before the next clk edge. start with mask=0 -> busy stays 0.
- DWELL=1 corner: mask=4'b1111.
  -> selects advance every cycle; sample_valid high 4 consecutive cycles; frame_done on the 4th.
